// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu in the EXE stage.
// Optional early-out path for trivial quotients is enabled by defining DIV_EARLY_OUT_EN.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [4:0]       in_dest,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_dest,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             fin_q, sign1_q, sign2_q, is_div_q;
  logic [4:0]       dest_q;

  logic             accept, signed_op, in_div, s1, s2, early;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   rem_sh;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_new;

  function automatic logic [WIDTH-1:0] fixup(input logic [WIDTH-1:0] q,
                                             input logic [WIDTH-1:0] r,
                                             input logic sa, input logic sb,
                                             input logic dv);
    logic [WIDTH-1:0] qs, rs;
    qs = (sa ^ sb) ? (~q + 1'b1) : q;
    rs = sa ? (~r + 1'b1) : r;
    return dv ? qs : rs;
  endfunction

  // Op decode follows priority div_w > mod_w > div_wu > mod_wu for multi-hot codes.
  assign accept    = in_valid & in_ready & (|in_op) & ~flush;
  assign signed_op = in_op[3] | in_op[2];
  assign in_div    = in_op[3] | (~in_op[2] & in_op[1]);
  assign s1        = in_src1[WIDTH-1] & signed_op;
  assign s2        = in_src2[WIDTH-1] & signed_op;
  assign abs1      = s1 ? (~in_src1 + 1'b1) : in_src1;
  assign abs2      = s2 ? (~in_src2 + 1'b1) : in_src2;

`ifdef DIV_EARLY_OUT_EN
  assign early = (abs2 == '0) || (abs1 < abs2);
`else
  assign early = 1'b0;
`endif

  // One restoring step; when the trial succeeds the difference fits in WIDTH bits.
  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign no_borrow = (rem_sh >= {1'b0, dvs_q});
  assign rem_new   = no_borrow ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = early ? DONE : CALC;
      CALC: begin
        if (flush)      state_d = IDLE;
        else if (fin_q) state_d = DONE;
      end
      DONE: if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      fin_q      <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      is_div_q   <= 1'b0;
      dest_q     <= '0;
      out_result <= '0;
      out_dest   <= '0;
    end else if (accept) begin
      rem_q    <= '0;
      quo_q    <= abs1;
      dvs_q    <= abs2;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      sign1_q  <= s1;
      sign2_q  <= s2;
      is_div_q <= in_div;
      dest_q   <= in_dest;
      if (early) begin
        out_result <= fixup((abs2 == '0) ? '1 : '0, abs1, s1, s2, in_div);
        out_dest   <= in_dest;
      end
    end else if (state_q == CALC && !flush) begin
      if (!fin_q) begin
        rem_q <= rem_new;
        quo_q <= {quo_q[WIDTH-2:0], no_borrow};
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) fin_q <= 1'b1;
      end else begin
        // Extra cycle after the last step registers the sign-corrected result.
        out_result <= fixup(quo_q, rem_q, sign1_q, sign2_q, is_div_q);
        out_dest   <= dest_q;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a result scoreboard and behavioural reference model.
// Latency expectations follow DIV_EARLY_OUT_EN when it is defined.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [3:0]  in_op;
  logic [31:0] in_src1, in_src2;
  logic [4:0]  in_dest;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_result;
  logic [4:0]  out_dest;

  localparam logic [3:0] DIV_W = 4'b1000, MOD_W = 4'b0100, DIV_WU = 4'b0010, MOD_WU = 4'b0001;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic sgn, dv;
    logic [31:0] r;
    sgn = op[3] | op[2];
    dv  = op[3] | (!op[2] & op[1]);
    if (sgn) begin
      if (b == 32'd0) r = dv ? (a[31] ? 32'd1 : 32'hFFFF_FFFF) : a;
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = dv ? 32'h8000_0000 : 32'd0;
      else if (dv) r = $signed(a) / $signed(b);
      else r = $signed(a) % $signed(b);
    end else begin
      if (b == 32'd0) r = dv ? 32'hFFFF_FFFF : a;
      else if (dv) r = a / b;
      else r = a % b;
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic sgn;
    logic [31:0] ma, mb;
    sgn = op[3] | op[2];
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (mb == 32'd0 || ma < mb) return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input bit push);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_dest = d;
    if (push) begin
      e.res = model(op, a, b); e.dest = d; e.lat = model_lat(op, a, b);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_op = 4'd0; in_src1 = $urandom; in_src2 = $urandom;
    in_dest = 5'($urandom);
  endtask

  task automatic wait_result(input string tag, input int hold);
    int lat;
    exp_t e;
    logic [31:0] r0;
    lat = 0;
    e = sb.pop_front();
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_res"}, out_result, e.res);
    chk({tag, "_dest"}, 32'(out_dest), 32'(e.dest));
    r0 = out_result;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_res"}, out_result, r0);
      chk({tag, "_hold_flags"}, {29'd0, out_valid, in_ready, busy}, 32'b101);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_retire"}, {30'd0, out_valid, in_ready}, 32'b01);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] d);
    issue(op, a, b, d, 1'b1);
    wait_result(tag, 0);
  endtask

  initial begin
    int seen;
    int lat;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 4'd0; in_src1 = '0; in_src2 = '0; in_dest = '0;
    #12;
    chk("reset_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("reset_result", out_result, 32'd0);
    chk("reset_dest", 32'(out_dest), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run("divw_neg7_2", DIV_W, 32'hFFFF_FFF9, 32'd2, 5'd1);
    run("modw_neg7_2", MOD_W, 32'hFFFF_FFF9, 32'd2, 5'd2);
    run("divwu_big_2", DIV_WU, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run("modwu_big_2", MOD_WU, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run("divwu_by0", DIV_WU, 32'd123, 32'd0, 5'd3);
    run("modwu_by0", MOD_WU, 32'd123, 32'd0, 5'd4);
    run("divw_ovf", DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    run("modw_ovf", MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    run("divw_neg_by0", DIV_W, 32'hFFFF_FF9C, 32'd0, 5'd8);
    run("modw_neg_by0", MOD_W, 32'hFFFF_FF9C, 32'd0, 5'd9);
    run("multihot_hi", 4'b1100, 32'd100, 32'd7, 5'd10);
    run("multihot_lo", 4'b0011, 32'hFFFF_FF00, 32'd7, 5'd11);
    run("divw_3_10", DIV_W, 32'd3, 32'd10, 5'd12);
    run("divw_negs", DIV_W, 32'hFFFF_FC18, 32'hFFFF_FFF9, 5'd13);

    issue(MOD_W, 32'hFFFF_FFFD, 32'd10, 5'd14, 1'b1);
    wait_result("bp_modw", 10);

    for (int i = 0; i < 6; i++) begin
      logic [3:0] op;
      logic [31:0] opa, opb;
      op = 4'b0001 << $urandom_range(3, 0);
      opa = $urandom;
      opb = (i == 0) ? 32'd0 : ($urandom >> $urandom_range(28, 0));
      run("rand", op, opa, opb, 5'($urandom));
    end

    // Flush during CALC: op must vanish.
    issue(DIV_WU, 32'd1000, 32'd3, 5'd20, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_calc", {29'd0, out_valid, in_ready, busy}, 32'b010);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("flush_novalid", 32'(seen), 32'd0);
    run("after_flush", DIV_W, 32'd1000, 32'hFFFF_FFFD, 5'd21);

    // Flush in DONE beats out_ready.
    issue(MOD_WU, 32'd1000, 32'd3, 5'd22, 1'b0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    chk("done_reached", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done", {29'd0, out_valid, in_ready, busy}, 32'b010);

    // Flush in IDLE blocks accept; in_op==0 is never accepted.
    @(negedge clk);
    in_valid = 1'b1; in_op = DIV_W; in_src1 = 32'd9; in_src2 = 32'd3; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle", {30'd0, in_ready, busy}, 32'b10);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("zero_op", {30'd0, in_ready, busy}, 32'b10);

    // Async reset mid-CALC.
    issue(DIV_W, 32'd5000, 32'd7, 5'd23, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("rst_mid_result", out_result, 32'd0);
    chk("rst_mid_dest", 32'(out_dest), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("after_reset", MOD_W, 32'd5000, 32'd7, 5'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
